// File: rtl/wakeup_ctrl.sv
// rtl/wakeup_ctrl.sv - CPU sleep/wakeup initiator with timer and masked event wake sources
module wakeup_ctrl #(
  parameter int NUM_EVT       = 2,
  parameter int TIMER_W       = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int WAKE_HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_sleep,
  input  logic [NUM_EVT-1:0] ext_evt,
  input  logic [NUM_EVT-1:0] evt_mask,
  input  logic               timer_en,
  input  logic [TIMER_W-1:0] timer_period,
  output logic               wakeup,
  output logic [NUM_EVT:0]   wake_cause,
  output logic               wake_err
);

  localparam int HOLD_W = $clog2(WAKE_HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WAKE  = 2'd2
  } state_t;

  state_t                                 state;
  logic                                   sleep_prev;
  logic [SYNC_STAGES-1:0][NUM_EVT-1:0]    sync_q;
  logic [NUM_EVT-1:0]                     sync_prev;
  logic [NUM_EVT-1:0]                     evt_rise_q;
  logic [TIMER_W-1:0]                     cnt;
  logic [HOLD_W-1:0]                      hold_cnt;

  logic               sleep_rise;
  logic [NUM_EVT:0]   hits;

  // A CPU already asleep when reset releases looks like a fresh rise because sleep_prev clears.
  assign sleep_rise = cpu_sleep & ~sleep_prev;
  // Timer is live-gated; event rises are masked at the point of use so mask changes act at once.
  assign hits       = {evt_rise_q & evt_mask, timer_en & (cnt == '0)};

  // Track the previous sleep level for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sleep_prev <= 1'b0;
    else       sleep_prev <= cpu_sleep;
  end

  // Synchronize external events and register their rising edges as single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      sync_prev  <= '0;
      evt_rise_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_evt};
      sync_prev  <= sync_q[SYNC_STAGES-1];
      evt_rise_q <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  // Sleep/wake FSM with registered wakeup, cause capture, timer and hold supervision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wakeup     <= 1'b0;
      wake_cause <= '0;
      wake_err   <= 1'b0;
      cnt        <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wakeup <= 1'b0;
          if (sleep_rise) begin
            state      <= ARMED;
            cnt        <= timer_period;
            wake_cause <= '0;
          end
        end
        ARMED: begin
          if (!cpu_sleep) begin
            state <= IDLE;
          end else begin
            if (hits != '0) begin
              state      <= WAKE;
              wakeup     <= 1'b1;
              wake_cause <= hits;
              hold_cnt   <= '0;
            end
            // Counter stops at zero so a late timer_en still sees an expired timer.
            if (cnt != '0) cnt <= cnt - TIMER_W'(1);
          end
        end
        WAKE: begin
          if (!cpu_sleep) begin
            state  <= IDLE;
            wakeup <= 1'b0;
          end else if (hold_cnt != HOLD_W'(WAKE_HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_W'(WAKE_HOLD_MAX - 1)) wake_err <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          wakeup <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wakeup_ctrl.sv
// tb/tb_wakeup_ctrl.sv - self-checking bench for wakeup_ctrl against a timestamp reference model
module tb_wakeup_ctrl;

  localparam int SYNC  = 2;
  localparam int HOLD  = 15;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_WAKE  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_sleep;
  logic [1:0] ext_evt;
  logic [1:0] evt_mask;
  logic       timer_en;
  logic [7:0] timer_period;
  logic       wakeup;
  logic [2:0] wake_cause;
  logic       wake_err;

  int checks = 0;
  int errors = 0;

  // reference model: state plus timestamps of arming and waking
  int         m_state;
  int         cyc;
  int         arm_t;
  int         per;
  int         wake_t;
  logic [2:0] m_cause;
  logic       m_err;
  logic       m_sleep_prev;
  logic [1:0] hist[$];

  wakeup_ctrl #(
    .NUM_EVT(2), .TIMER_W(8), .SYNC_STAGES(SYNC), .WAKE_HOLD_MAX(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .cpu_sleep(cpu_sleep), .ext_evt(ext_evt),
    .evt_mask(evt_mask), .timer_en(timer_en), .timer_period(timer_period),
    .wakeup(wakeup), .wake_cause(wake_cause), .wake_err(wake_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    cyc = 0; arm_t = 0; per = 0; wake_t = 0;
    m_cause = '0; m_err = 1'b0; m_sleep_prev = 1'b0;
    hist.delete();
    for (int i = 0; i < 5; i++) hist.push_back(2'b00);
  endtask

  // One clock edge of the specification's rules; an event sampled high at edge E
  // (low at E-1) is seen as a wake source at edge E+SYNC+1.
  task automatic model_edge();
    logic [1:0] rise;
    logic [2:0] hits;
    logic       srise;
    hist.push_back(ext_evt);
    if (hist.size() > 10) void'(hist.pop_front());
    rise  = hist[hist.size()-1-(SYNC+1)] & ~hist[hist.size()-1-(SYNC+2)];
    srise = cpu_sleep & ~m_sleep_prev;
    m_sleep_prev = cpu_sleep;
    case (m_state)
      M_IDLE: if (srise) begin
        m_state = M_ARMED; arm_t = cyc; per = int'(timer_period); m_cause = '0;
      end
      M_ARMED: if (!cpu_sleep) m_state = M_IDLE;
      else begin
        hits = {rise & evt_mask, timer_en && (cyc >= arm_t + per + 1)};
        if (hits != 3'b000) begin
          m_state = M_WAKE; m_cause = hits; wake_t = cyc;
        end
      end
      default: if (!cpu_sleep) m_state = M_IDLE;
      else if (cyc - wake_t >= HOLD) m_err = 1'b1;
    endcase
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("wakeup", 32'(wakeup), 32'(m_state == M_WAKE));
    check("wake_cause", 32'(wake_cause), 32'(m_cause));
    check("wake_err", 32'(wake_err), 32'(m_err));
  endtask

  // Asynchronous reset between edges, held across one edge, released after it.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_wakeup", 32'(wakeup), 32'd0);
    check("rst_cause", 32'(wake_cause), 32'd0);
    check("rst_err", 32'(wake_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // 1: reset with cpu_sleep high, then arming on release
    reset = 1'b1; cpu_sleep = 1'b1; ext_evt = '0; evt_mask = '0;
    timer_en = 1'b1; timer_period = 8'd0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("t1_rst_wakeup", 32'(wakeup), 32'd0);
    check("t1_rst_cause", 32'(wake_cause), 32'd0);
    check("t1_rst_err", 32'(wake_err), 32'd0);
    reset = 1'b0;
    tick();
    check("t1_armed_no_wake", 32'(wakeup), 32'd0);
    tick();
    check("t1_wake_p0", 32'(wakeup), 32'd1);
    cpu_sleep = 1'b0;
    tick();

    // 2: timer wake with period 5 -> wakeup after S+6
    timer_en = 1'b1; timer_period = 8'd5; evt_mask = 2'b00; cpu_sleep = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) tick();
    check("t2_before", 32'(wakeup), 32'd0);
    tick();
    check("t2_wake", 32'(wakeup), 32'd1);
    check("t2_cause", 32'(wake_cause), 32'd1);
    cpu_sleep = 1'b0;
    tick();
    check("t2_drop", 32'(wakeup), 32'd0);
    check("t2_hold_cause", 32'(wake_cause), 32'd1);

    // 3: masked event sources
    timer_en = 1'b0; evt_mask = 2'b10; cpu_sleep = 1'b1;
    tick(); tick();
    ext_evt = 2'b10;
    tick(); tick(); tick();
    check("t3_before", 32'(wakeup), 32'd0);
    ext_evt = 2'b00;
    tick();
    check("t3_wake", 32'(wakeup), 32'd1);
    check("t3_cause", 32'(wake_cause), 32'd4);
    cpu_sleep = 1'b0;
    tick(); tick();
    cpu_sleep = 1'b1;
    tick(); tick();
    ext_evt = 2'b01;
    tick(); tick(); tick();
    ext_evt = 2'b00;
    for (int k = 0; k < 6; k++) tick();
    check("t3_masked_no_wake", 32'(wakeup), 32'd0);
    cpu_sleep = 1'b0;
    tick();

    // 4: timer expiry coincides with enabled ext_evt[0] edge
    evt_mask = 2'b01; timer_en = 1'b1; timer_period = 8'd6; cpu_sleep = 1'b1;
    tick();
    tick(); tick(); tick();
    ext_evt = 2'b01;
    tick(); tick(); tick();
    check("t4_before", 32'(wakeup), 32'd0);
    tick();
    check("t4_wake", 32'(wakeup), 32'd1);
    check("t4_cause", 32'(wake_cause), 32'd3);
    cpu_sleep = 1'b0; ext_evt = 2'b00;
    tick(); tick();

    // 5: CPU stays asleep through WAKE -> wake_err, then reset mid-WAKE
    evt_mask = 2'b00; timer_en = 1'b1; timer_period = 8'd0; cpu_sleep = 1'b1;
    tick(); tick();
    check("t5_wake", 32'(wakeup), 32'd1);
    for (int k = 1; k <= 14; k++) tick();
    check("t5_err_early", 32'(wake_err), 32'd0);
    tick();
    check("t5_err", 32'(wake_err), 32'd1);
    check("t5_wake_held", 32'(wakeup), 32'd1);
    tick(); tick();
    cpu_sleep = 1'b0;
    do_reset();

    // 6: sleep abandoned in ARMED before any source
    timer_en = 1'b1; timer_period = 8'd20; cpu_sleep = 1'b1;
    tick(); tick(); tick(); tick();
    cpu_sleep = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("t6_no_wake", 32'(wakeup), 32'd0);
    check("t6_cause", 32'(wake_cause), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) cpu_sleep = ~cpu_sleep;
      if ($urandom_range(0, 3) == 0) ext_evt[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 40) == 0) evt_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) timer_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 20) == 0) timer_period = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 400) == 0) do_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
